load_store_unit: RTL and testbench

Parametrised multicycle load/store unit sitting between the core's execute stage and the data memory port. It accepts one load or store request at a time and issues a word-aligned access using per-byte lane enables instead of read-modify-write. It waits on a memory ready handshake, returns sign- or zero-extended load data, and reports misalignment, illegal-width and timeout faults. It supersedes the core's inline SB/SW handling and supports all RV32I widths, plus RV64I widths when XLEN=64.

---
 rtl/load_store_unit_if.sv | 48 ++++
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus bundle between the core execute stage, the load/store unit and the
// data memory port. The unit is the "slave" side; the core/memory
// environment is the "master" side.
//
// Handshake rules: a request transfers on a rising edge where
// req_valid && req_ready; a response transfers on a rising edge where
// rsp_valid && rsp_ready. A valid, once raised, holds its payload stable
// until the transfer edge. On the memory side, mem_re/mem_we with
// address, data and enables stay stable until a cycle with mem_ready=1
// (or the unit's timeout) completes the access.
interface load_store_unit_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int NB = XLEN / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [XLEN-1:0]       req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [XLEN-1:0]       rsp_rdata;
  logic [1:0]            rsp_status;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [XLEN-1:0]       mem_data_out;
  logic [NB-1:0]         mem_byte_enable;
  logic                  mem_we;
  logic                  mem_re;
  logic [XLEN-1:0]       mem_data_in;
  logic                  mem_ready;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
           rsp_ready, mem_data_in, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_status,
           mem_address, mem_data_out, mem_byte_enable, mem_we, mem_re
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
           rsp_ready, mem_data_in, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_status,
           mem_address, mem_data_out, mem_byte_enable, mem_we, mem_re
  );
endinterface

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: one request at a time, word-aligned access
// with byte-lane enables, sign/zero extension of load data, and
// misaligned / illegal-width / timeout faults. All outputs are registered.
// state_dbg exposes the FSM: 0 = IDLE, 1 = ACCESS, 2 = RESP.
module load_store_unit #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus,
  output logic [1:0]        state_dbg
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t                state, state_d;
  logic [OB-1:0]         off_q, off_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  write_q, write_d;
  logic [CW-1:0]         wait_q, wait_d;

  logic                  req_ready_d, rsp_valid_d, mem_we_d, mem_re_d;
  logic [XLEN-1:0]       rsp_rdata_d, mem_data_out_d;
  logic [1:0]            rsp_status_d;
  logic [ADDR_WIDTH-1:0] mem_address_d;
  logic [NB-1:0]         mem_byte_enable_d;

  logic                  legal, misaligned;
  logic [OB-1:0]         req_off;
  logic [NB-1:0]         lane_base;
  logic [XLEN-1:0]       shifted, left, load_data;
  logic [6:0]            sh;

  assign state_dbg = state;
  assign req_off   = bus.req_addr[OB-1:0];

  // Decode the incoming request: width legality, alignment, lane mask.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    lane_base  = '0;
    if (bus.req_write) begin
      case (bus.req_funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = (XLEN == 64);
        default:                legal = 1'b0;
      endcase
    end else begin
      case (bus.req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = (XLEN == 64);
        default:                                legal = 1'b0;
      endcase
    end
    case (bus.req_funct3[1:0])
      2'd0: begin misaligned = 1'b0;               lane_base = NB'(8'h01); end
      2'd1: begin misaligned = bus.req_addr[0];    lane_base = NB'(8'h03); end
      2'd2: begin misaligned = |bus.req_addr[1:0]; lane_base = NB'(8'h0F); end
      default: begin misaligned = |bus.req_addr[2:0]; lane_base = NB'(8'hFF); end
    endcase
  end

  // Extract the addressed field from the read word and extend it: shift the
  // field to the top, then shift back logically (zero) or arithmetically (sign).
  always_comb begin
    shifted = bus.mem_data_in >> {off_q, 3'b000};
    case (funct3_q[1:0])
      2'd0:    sh = 7'(XLEN - 8);
      2'd1:    sh = 7'(XLEN - 16);
      2'd2:    sh = 7'(XLEN - 32);
      default: sh = 7'd0;
    endcase
    left = shifted << sh;
    if (funct3_q[2]) load_data = left >> sh;
    else             load_data = $unsigned($signed(left) >>> sh);
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d           = state;
    off_d             = off_q;
    funct3_d          = funct3_q;
    write_d           = write_q;
    wait_d            = wait_q;
    req_ready_d       = bus.req_ready;
    rsp_valid_d       = bus.rsp_valid;
    rsp_rdata_d       = bus.rsp_rdata;
    rsp_status_d      = bus.rsp_status;
    mem_address_d     = bus.mem_address;
    mem_data_out_d    = bus.mem_data_out;
    mem_byte_enable_d = bus.mem_byte_enable;
    mem_we_d          = bus.mem_we;
    mem_re_d          = bus.mem_re;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          off_d       = req_off;
          funct3_d    = bus.req_funct3;
          write_d     = bus.req_write;
          req_ready_d = 1'b0;
          if (!legal || misaligned) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = '0;
            rsp_status_d = !legal ? 2'b11 : 2'b01;
          end else begin
            state_d           = ACCESS;
            wait_d            = '0;
            mem_re_d          = !bus.req_write;
            mem_we_d          = bus.req_write;
            mem_address_d     = {bus.req_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
            mem_byte_enable_d = lane_base << req_off;
            mem_data_out_d    = bus.req_wdata << {req_off, 3'b000};
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ready || (TIMEOUT != 0 && wait_q == CW'(TIMEOUT))) begin
          state_d           = RESP;
          rsp_valid_d       = 1'b1;
          rsp_status_d      = bus.mem_ready ? 2'b00 : 2'b10;
          rsp_rdata_d       = (bus.mem_ready && !write_q) ? load_data : '0;
          mem_re_d          = 1'b0;
          mem_we_d          = 1'b0;
          mem_byte_enable_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d      = IDLE;
          rsp_valid_d  = 1'b0;
          rsp_rdata_d  = '0;
          rsp_status_d = 2'b00;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      off_q               <= '0;
      funct3_q            <= '0;
      write_q             <= 1'b0;
      wait_q              <= '0;
      bus.req_ready       <= 1'b1;
      bus.rsp_valid       <= 1'b0;
      bus.rsp_rdata       <= '0;
      bus.rsp_status      <= 2'b00;
      bus.mem_address     <= '0;
      bus.mem_data_out    <= '0;
      bus.mem_byte_enable <= '0;
      bus.mem_we          <= 1'b0;
      bus.mem_re          <= 1'b0;
    end else begin
      state               <= state_d;
      off_q               <= off_d;
      funct3_q            <= funct3_d;
      write_q             <= write_d;
      wait_q              <= wait_d;
      bus.req_ready       <= req_ready_d;
      bus.rsp_valid       <= rsp_valid_d;
      bus.rsp_rdata       <= rsp_rdata_d;
      bus.rsp_status      <= rsp_status_d;
      bus.mem_address     <= mem_address_d;
      bus.mem_data_out    <= mem_data_out_d;
      bus.mem_byte_enable <= mem_byte_enable_d;
      bus.mem_we          <= mem_we_d;
      bus.mem_re          <= mem_re_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit
// instance (TIMEOUT=6) share stimulus; sel picks the one under test.
module tb_load_store_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sel;
  logic        req_valid, req_write, rsp_ready, mem_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_data_in;
  logic [1:0]  st32, st64;

  load_store_unit_if #(.XLEN(32), .ADDR_WIDTH(32)) b32();
  load_store_unit_if #(.XLEN(64), .ADDR_WIDTH(32)) b64();

  assign b32.req_valid   = req_valid & ~sel;
  assign b32.req_write   = req_write;
  assign b32.req_funct3  = req_funct3;
  assign b32.req_addr    = req_addr;
  assign b32.req_wdata   = req_wdata[31:0];
  assign b32.rsp_ready   = rsp_ready & ~sel;
  assign b32.mem_data_in = mem_data_in[31:0];
  assign b32.mem_ready   = mem_ready & ~sel;
  assign b64.req_valid   = req_valid & sel;
  assign b64.req_write   = req_write;
  assign b64.req_funct3  = req_funct3;
  assign b64.req_addr    = req_addr;
  assign b64.req_wdata   = req_wdata;
  assign b64.rsp_ready   = rsp_ready & sel;
  assign b64.mem_data_in = mem_data_in;
  assign b64.mem_ready   = mem_ready & sel;

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .reset(reset), .bus(b32), .state_dbg(st32));
  load_store_unit #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT(6)) dut64 (
    .clk(clk), .reset(reset), .bus(b64), .state_dbg(st64));

  logic        o_req_ready, o_rsp_valid, o_we, o_re;
  logic [63:0] o_rdata, o_data_out;
  logic [1:0]  o_status, o_state;
  logic [31:0] o_addr;
  logic [7:0]  o_be;
  assign o_req_ready = sel ? b64.req_ready : b32.req_ready;
  assign o_rsp_valid = sel ? b64.rsp_valid : b32.rsp_valid;
  assign o_we        = sel ? b64.mem_we : b32.mem_we;
  assign o_re        = sel ? b64.mem_re : b32.mem_re;
  assign o_rdata     = sel ? b64.rsp_rdata : {32'b0, b32.rsp_rdata};
  assign o_data_out  = sel ? b64.mem_data_out : {32'b0, b32.mem_data_out};
  assign o_status    = sel ? b64.rsp_status : b32.rsp_status;
  assign o_addr      = sel ? b64.mem_address : b32.mem_address;
  assign o_be        = sel ? b64.mem_byte_enable : {4'b0, b32.mem_byte_enable};
  assign o_state     = sel ? st64 : st32;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  status;
    logic [63:0] rdata;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] data_out;
  } exp_t;

  // Reference: what the unit must report for one request, from the ISA rules.
  function automatic exp_t model(input int xlen, input bit wr, input bit [2:0] f3,
                                 input bit [31:0] a, input bit [63:0] wd,
                                 input bit [63:0] md, input bit timed);
    exp_t e;
    int nb, size, off;
    bit legal;
    bit [63:0] xmask, fmask, v;
    e = '{default: '0};
    nb    = xlen / 8;
    size  = 1 << f3[1:0];
    off   = int'(a % nb);
    xmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (wr) legal = (f3 <= 3'd2) || (f3 == 3'd3 && xlen == 64);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                    (xlen == 64 && f3 inside {3'd3, 3'd6});
    e.addr     = a - off;
    e.be       = 8'(((1 << size) - 1) << off);
    e.data_out = ((wd & xmask) << (8 * off)) & xmask;
    if (!legal) e.status = 2'b11;
    else if (a % size != 0) e.status = 2'b01;
    else if (timed) e.status = 2'b10;
    else if (!wr) begin
      fmask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * size)) - 64'd1;
      v = ((md & xmask) >> (8 * off)) & fmask;
      if (!f3[2] && v[8 * size - 1]) v = v | ~fmask;
      e.rdata = v & xmask;
    end
    return e;
  endfunction

  task automatic run_txn(input bit s, input bit wr, input bit [2:0] f3, input bit [31:0] a,
                         input bit [63:0] wd, input bit [63:0] md, input int waits,
                         input int hold);
    int   to, cyc, we_done;
    bit   timed, fault;
    exp_t e;
    sel = s;
    to  = s ? 6 : 4;
    @(negedge clk);
    chk("req_ready_idle", 64'(o_req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a;
    req_wdata = wd; mem_data_in = md; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    timed = (waits > to);
    e = model(s ? 64 : 32, wr, f3, a, wd, md, timed);
    fault = (e.status == 2'b01) || (e.status == 2'b11);
    if (fault) begin
      chk("fault_re", 64'(o_re), 64'd0);
      chk("fault_we", 64'(o_we), 64'd0);
    end else begin
      chk("mem_address", 64'(o_addr), 64'(e.addr));
      chk("mem_data_out", o_data_out, e.data_out);
      chk("mem_re", 64'(o_re), 64'(!wr));
      chk("mem_we", 64'(o_we), 64'(wr));
      chk("req_ready_busy", 64'(o_req_ready), 64'd0);
      cyc = 0; we_done = 0;
      while ((o_re || o_we) && cyc < 50) begin
        chk("be_stable", 64'(o_be), 64'(e.be));
        mem_ready = (cyc == waits);
        if (o_we && mem_ready) we_done++;
        cyc++;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
      end
      chk("access_cycles", 64'(cyc), 64'(timed ? to + 1 : waits + 1));
      if (wr && !timed) chk("store_once", 64'(we_done), 64'd1);
      chk("strobe_drop", 64'({o_re, o_we}), 64'd0);
    end
    chk("rsp_valid", 64'(o_rsp_valid), 64'd1);
    chk("rsp_status", 64'(o_status), 64'(e.status));
    chk("rsp_rdata", o_rdata, e.rdata);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("rsp_hold_valid", 64'(o_rsp_valid), 64'd1);
      chk("rsp_hold_status", 64'(o_status), 64'(e.status));
      chk("rsp_hold_req_ready", 64'(o_req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", 64'(o_rsp_valid), 64'd0);
    chk("rsp_done_req_ready", 64'(o_req_ready), 64'd1);
  endtask

  task automatic reset_checks(input bit s);
    sel = s;
    #1;
    chk("rst_req_ready", 64'(o_req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_rdata", o_rdata, 64'd0);
    chk("rst_status", 64'(o_status), 64'd0);
    chk("rst_strobes", 64'({o_re, o_we}), 64'd0);
    chk("rst_be", 64'(o_be), 64'd0);
    chk("rst_addr", 64'(o_addr), 64'd0);
    chk("rst_data_out", o_data_out, 64'd0);
    chk("rst_state", 64'(o_state), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [2:0]  f3;
    bit [31:0] a;
    int        size;
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
    mem_ready = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; mem_data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    reset_checks(1'b0);
    reset_checks(1'b1);

    // Directed steps on the 32-bit unit.
    run_txn(0, 0, 3'b010, 32'h100, 64'h0, 64'hDEADBEEF, 0, 0);  // LW
    run_txn(0, 0, 3'b000, 32'h103, 64'h0, 64'h80123456, 0, 0);  // LB
    run_txn(0, 0, 3'b100, 32'h103, 64'h0, 64'h80123456, 1, 0);  // LBU
    run_txn(0, 0, 3'b101, 32'h102, 64'h0, 64'h80123456, 2, 1);  // LHU
    run_txn(0, 1, 3'b000, 32'h201, 64'hAB, 64'h0, 0, 0);        // SB
    run_txn(0, 1, 3'b001, 32'h301, 64'h1234, 64'h0, 0, 0);      // SH misaligned
    run_txn(0, 0, 3'b011, 32'h400, 64'h0, 64'h0, 0, 0);         // LD illegal on 32
    run_txn(0, 0, 3'b010, 32'h500, 64'h0, 64'h0, 99, 3);        // LW timeout
    run_txn(0, 1, 3'b010, 32'h600, 64'hCAFEF00D, 64'h0, 4, 0);  // SW, ready at last wait
    // Directed steps on the 64-bit unit.
    run_txn(1, 0, 3'b110, 32'h404, 64'h0, 64'hF000000100000000, 2, 0);  // LWU
    run_txn(1, 1, 3'b011, 32'h408, 64'h0123456789ABCDEF, 64'h0, 1, 0);  // SD
    run_txn(1, 0, 3'b011, 32'h40C, 64'h0, 64'h0, 0, 0);                  // LD misaligned

    // Reset during the ACCESS of an SD.
    sel = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011; req_addr = 32'h700;
    req_wdata = 64'h1122334455667788; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("sd_we_before_reset", 64'(o_we), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("sd_reset_we", 64'(o_we), 64'd0);
    chk("sd_reset_req_ready", 64'(o_req_ready), 64'd1);
    chk("sd_reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("sd_reset_be", 64'(o_be), 64'd0);
    chk("sd_reset_addr", 64'(o_addr), 64'd0);

    // Randomized requests on either unit.
    for (int i = 0; i < 60; i++) begin
      f3   = 3'($urandom_range(0, 7));
      size = 1 << f3[1:0];
      a    = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size) - 32'd1);
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, a,
              {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 3),
              $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
